// File: rtl/i3c_sdr_target_fsm.sv
// I3C SDR target frame engine: START/Sr/STOP framing, broadcast/static/dynamic
// address match, ACK, private write and private read with T-bit handling.
// Optional macro I3C_TGT_PARITY_CHK_EN enables write T-bit odd-parity checking.
module i3c_sdr_target_fsm #(
  parameter logic [6:0]  STATIC_ADDR = 7'h2A,
  parameter logic [6:0]  BCAST_ADDR  = 7'h7E,
  parameter int unsigned MAX_WR_LEN  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_rise,
  input  logic       scl_fall,
  input  logic       start_det,
  input  logic       stop_det,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       sda_out,
  input  logic [6:0] dyn_addr,
  input  logic       dyn_addr_vld,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       rnw
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WCNT_W = 16;

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK, BCAST, WDATA, WTBIT, RDATA, RTBIT, WAIT_SR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         sh_q, sh_d;
  logic [WCNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic               ack_ph_q, ack_ph_d;
  logic               bcast_q, bcast_d;
  logic               last_q, last_d;
  logic               sda_oe_q, sda_oe_d;
  logic               sda_out_q, sda_out_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_err_q, rx_err_d;
  logic               tx_ready_q, tx_ready_d;
  logic               busy_q, busy_d;
  logic               rnw_q, rnw_d;
  logic               bcast_hit, own_hit, parity_fail, wr_limit;

  // Address decode on the 7 shifted bits plus the RnW bit currently on sda_in
  assign bcast_hit = (sh_q[6:0] == BCAST_ADDR) && !sda_in;
  assign own_hit   = (sh_q[6:0] == STATIC_ADDR) ||
                     (dyn_addr_vld && (sh_q[6:0] == dyn_addr));
  assign wr_limit  = (MAX_WR_LEN != 0) && (wr_cnt_q == WCNT_W'(MAX_WR_LEN - 1));

`ifdef I3C_TGT_PARITY_CHK_EN
  assign parity_fail = (sda_in != ~^sh_q);
`else
  assign parity_fail = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    wr_cnt_d   = wr_cnt_q;
    ack_ph_d   = ack_ph_q;
    bcast_d    = bcast_q;
    last_d     = last_q;
    sda_oe_d   = sda_oe_q;
    sda_out_d  = sda_out_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    tx_ready_d = 1'b0;
    rnw_d      = rnw_q;

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      sda_out_d = 1'b1;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      wr_cnt_d  = '0;
      ack_ph_d  = 1'b0;
      bcast_d   = 1'b0;
      sda_oe_d  = 1'b0;
      sda_out_d = 1'b1;
    end else begin
      case (state_q)
        IDLE, BCAST, WAIT_SR: begin
          sda_oe_d  = 1'b0;
          sda_out_d = 1'b1;
        end
        ADDR: if (scl_rise) begin
          if (bit_cnt_q == CNT_W'(7)) begin
            rnw_d    = sda_in;
            ack_ph_d = 1'b0;
            if (bcast_hit) begin
              state_d = ACK;
              bcast_d = 1'b1;
            end else if (own_hit && !(sda_in && !tx_valid)) begin
              state_d = ACK;
            end else begin
              state_d = WAIT_SR;
            end
          end else begin
            sh_d      = {sh_q[6:0], sda_in};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ACK: if (scl_fall) begin
          if (!ack_ph_q) begin
            ack_ph_d  = 1'b1;
            sda_oe_d  = 1'b1;
            sda_out_d = 1'b0;
          end else begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            sda_out_d = 1'b1;
            if (bcast_q) begin
              state_d = BCAST;
            end else if (!rnw_q) begin
              state_d = WDATA;
            end else if (tx_valid) begin
              state_d    = RDATA;
              sh_d       = tx_data;
              last_d     = tx_last;
              tx_ready_d = 1'b1;
              sda_oe_d   = 1'b1;
              sda_out_d  = tx_data[7];
              bit_cnt_d  = CNT_W'(1);
            end else begin
              state_d = WAIT_SR;
            end
          end
        end
        WDATA: if (scl_rise) begin
          sh_d = {sh_q[6:0], sda_in};
          if (bit_cnt_q == CNT_W'(7)) begin
            state_d   = WTBIT;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        WTBIT: if (scl_rise) begin
          if (parity_fail) begin
            rx_err_d = 1'b1;
            state_d  = WAIT_SR;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = sh_q;
            wr_cnt_d   = wr_cnt_q + WCNT_W'(1);
            state_d    = wr_limit ? WAIT_SR : WDATA;
          end
        end
        RDATA: if (scl_fall) begin
          if (bit_cnt_q == CNT_W'(8)) begin
            state_d   = RTBIT;
            sda_out_d = ~last_q;
          end else begin
            sh_d      = {sh_q[6:0], 1'b0};
            sda_out_d = sh_q[6];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        RTBIT: if (scl_fall) begin
          if (!last_q && tx_valid) begin
            state_d    = RDATA;
            sh_d       = tx_data;
            last_d     = tx_last;
            tx_ready_d = 1'b1;
            sda_out_d  = tx_data[7];
            bit_cnt_d  = CNT_W'(1);
          end else begin
            state_d   = WAIT_SR;
            sda_oe_d  = 1'b0;
            sda_out_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      wr_cnt_q   <= '0;
      ack_ph_q   <= 1'b0;
      bcast_q    <= 1'b0;
      last_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      sda_out_q  <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      rnw_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      wr_cnt_q   <= wr_cnt_d;
      ack_ph_q   <= ack_ph_d;
      bcast_q    <= bcast_d;
      last_q     <= last_d;
      sda_oe_q   <= sda_oe_d;
      sda_out_q  <= sda_out_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      rnw_q      <= rnw_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign sda_out  = sda_out_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign rnw      = rnw_q;

endmodule

// File: tb/tb_i3c_sdr_target_fsm.sv
// Directed bench for i3c_sdr_target_fsm: acts as the SCL/SDA detector and controller.
module tb_i3c_sdr_target_fsm;

`ifdef I3C_TGT_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_rise, scl_fall, start_det, stop_det, sda_in;
  logic       sda_oe, sda_out;
  logic [6:0] dyn_addr;
  logic       dyn_addr_vld;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, tx_ready, busy, rnw;

  int checks = 0;
  int errors = 0;
  int n_rxv = 0, n_rxe = 0, n_txr = 0;
  logic [7:0] last_rx = 8'h00;

  i3c_sdr_target_fsm dut (
    .clk(clk), .rst_n(rst_n), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .sda_in(sda_in),
    .sda_oe(sda_oe), .sda_out(sda_out), .dyn_addr(dyn_addr),
    .dyn_addr_vld(dyn_addr_vld), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .rnw(rnw)
  );

  always #5 clk = ~clk;

  // Count one-clk pulses; each pulse spans exactly one falling edge
  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv   = n_rxv + 1;
      last_rx = rx_data;
    end
    if (rx_err)   n_rxe = n_rxe + 1;
    if (tx_ready) n_txr = n_txr + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start_det = 1'b1;
    @(negedge clk); start_det = 1'b0;
    idle(2);
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop_det = 1'b1;
    @(negedge clk); stop_det = 1'b0;
  endtask

  // One SCL period; returns the target drive seen while SCL is high
  task automatic bit_cycle(input logic b, output logic oe, output logic o);
    @(negedge clk); sda_in = b;
    idle(2);
    @(negedge clk); scl_rise = 1'b1; oe = sda_oe; o = sda_out;
    @(negedge clk); scl_rise = 1'b0;
    idle(2);
    @(negedge clk); scl_fall = 1'b1;
    @(negedge clk); scl_fall = 1'b0;
    idle(1);
  endtask

  task automatic send_addr(input logic [6:0] a, input logic r, output logic ack);
    logic oe, o;
    for (int i = 6; i >= 0; i--) bit_cycle(a[i], oe, o);
    bit_cycle(r, oe, o);
    bit_cycle(1'b1, oe, o);
    ack = oe & ~o;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic t, output logic any_oe);
    logic oe, o;
    any_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(d[i], oe, o);
      any_oe = any_oe | oe;
    end
    bit_cycle(t, oe, o);
    any_oe = any_oe | oe;
  endtask

  // Reads n bits MSB first as the controller sees the bus (pulled up when released)
  task automatic read_bits(input int n, output logic [8:0] v);
    logic oe, o;
    v = '0;
    for (int i = 0; i < n; i++) begin
      bit_cycle(1'b1, oe, o);
      v = {v[7:0], (oe ? o : 1'b1)};
    end
  endtask

  initial begin
    logic       ack, any_oe;
    logic [8:0] v;
    int         base_v, base_e, base_t;

    rst_n = 1'b0; scl_rise = 1'b0; scl_fall = 1'b0; start_det = 1'b0;
    stop_det = 1'b0; sda_in = 1'b1; dyn_addr = 7'h15; dyn_addr_vld = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
    idle(3);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_sda_out", 32'(sda_out), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_pulses", {29'd0, rx_valid, rx_err, tx_ready}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rnw", 32'(rnw), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // Private write 0xA5, T=1, to the static address
    pulse_start();
    chk("wr_busy", 32'(busy), 32'd1);
    send_addr(7'h2A, 1'b0, ack);
    chk("wr_ack", 32'(ack), 32'd1);
    chk("wr_rnw", 32'(rnw), 32'd0);
    write_byte(8'hA5, 1'b1, any_oe);
    chk("wr_no_drive", 32'(any_oe), 32'd0);
    chk("wr_rxv_cnt", 32'(n_rxv), 32'd1);
    chk("wr_rx_data", 32'(last_rx), 32'hA5);
    pulse_stop();
    chk("wr_stop_oe", 32'(sda_oe), 32'd0);
    chk("wr_stop_busy", 32'(busy), 32'd0);

    // Broadcast write, then Sr and single-byte read of 0x3C
    pulse_start();
    send_addr(7'h7E, 1'b0, ack);
    chk("bc_ack", 32'(ack), 32'd1);
    write_byte(8'h55, 1'b1, any_oe);
    chk("bc_no_drive", 32'(any_oe), 32'd0);
    chk("bc_ignored", 32'(n_rxv), 32'd1);
    tx_data = 8'h3C; tx_valid = 1'b1; tx_last = 1'b1;
    pulse_start();
    send_addr(7'h2A, 1'b1, ack);
    chk("rd_ack", 32'(ack), 32'd1);
    chk("rd_rnw", 32'(rnw), 32'd1);
    read_bits(9, v);
    chk("rd_byte_t", 32'(v), 32'h078);
    chk("rd_released", 32'(sda_oe), 32'd0);
    chk("rd_txr_cnt", 32'(n_txr), 32'd1);
    tx_valid = 1'b0;
    pulse_stop();

    // Dynamic address: not valid, then valid
    pulse_start();
    send_addr(7'h15, 1'b0, ack);
    chk("dyn_nack", 32'(ack), 32'd0);
    chk("dyn_wait_busy", 32'(busy), 32'd1);
    pulse_stop();
    dyn_addr_vld = 1'b1;
    pulse_start();
    send_addr(7'h15, 1'b0, ack);
    chk("dyn_ack", 32'(ack), 32'd1);
    pulse_stop();

    // T-bit handling: 0x80/T=0 is correct odd parity, 0x81/T=0 is not
    base_v = n_rxv; base_e = n_rxe;
    pulse_start();
    send_addr(7'h2A, 1'b0, ack);
    write_byte(8'h80, 1'b0, any_oe);
    chk("par80_data", 32'(last_rx), 32'h80);
    write_byte(8'h81, 1'b0, any_oe);
    chk("par_rxv_cnt", 32'(n_rxv - base_v), PAR_EN ? 32'd1 : 32'd2);
    chk("par_err_cnt", 32'(n_rxe - base_e), PAR_EN ? 32'd1 : 32'd0);
    chk("par_last_rx", 32'(last_rx), PAR_EN ? 32'h80 : 32'h81);
    pulse_stop();

    // Read with nothing to send is NACKed
    base_t = n_txr;
    tx_valid = 1'b0;
    pulse_start();
    send_addr(7'h2A, 1'b1, ack);
    chk("rdnv_nack", 32'(ack), 32'd0);
    chk("rdnv_busy", 32'(busy), 32'd1);
    chk("rdnv_no_txr", 32'(n_txr - base_t), 32'd0);
    pulse_stop();

    // Two-byte read, STOP in the middle of the second byte
    base_t = n_txr;
    tx_data = 8'h11; tx_valid = 1'b1; tx_last = 1'b0;
    pulse_start();
    send_addr(7'h2A, 1'b1, ack);
    chk("rd2_ack", 32'(ack), 32'd1);
    tx_data = 8'h22; tx_last = 1'b1;
    read_bits(9, v);
    chk("rd2_byte1_t", 32'(v), 32'h023);
    read_bits(4, v);
    chk("rd2_nibble", 32'(v), 32'h002);
    chk("rd2_driving", 32'(sda_oe), 32'd1);
    pulse_stop();
    chk("rd2_stop_oe", 32'(sda_oe), 32'd0);
    chk("rd2_stop_busy", 32'(busy), 32'd0);
    chk("rd2_txr_cnt", 32'(n_txr - base_t), 32'd2);
    tx_valid = 1'b0;
    idle(2);

    // Asynchronous reset while the ACK is being driven
    pulse_start();
    for (int i = 6; i >= 0; i--) begin
      logic oe, o;
      bit_cycle(v[0] ^ (i == 1 || i == 3 || i == 5), oe, o);
    end
    begin
      logic oe, o;
      bit_cycle(1'b0, oe, o);
    end
    chk("arst_ack_drive", 32'(sda_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("arst_release", 32'(sda_oe), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
